neopixel_strand_ctrl: RTL



---
 rtl/neopixel_strand_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/neopixel_strand_ctrl.sv
// ============================================================================
// neopixel_strand_ctrl
// ----------------------------------------------------------------------------
// Drives a WS2812-class strand of NUM_NPX pixels from a write-side pixel
// buffer. Per-pixel loads and whole-buffer clears are accepted at any time;
// a transmission works from a frame snapshot taken in START, so writes made
// during a frame only show up in the next one. Each frame is sent pixel 0
// first, GRB order, MSB first, followed by a LATCH_CYC low gap.
//
// After reset the controller immediately sends an all-zero frame to blank
// the strand, then waits in IDLE for go.
//
// Optional feature (macro NPX_BRIGHTNESS_EN): adds an 8-bit brightness
// input sampled in START; every transmitted byte c becomes
// (c * (brightness + 1)) >> 8.
//
// Ports:
//   CLOCK_50      in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   red/green/blue in  8-bit colour for a load
//   pixel         in   target pixel index for a load
//   load          in   write {green,red,blue} to buffer[pixel]
//   clear         in   zero the whole buffer (wins over load)
//   go            in   start a frame (accepted only while ready)
//   brightness    in   global scale (only with NPX_BRIGHTNESS_EN)
//   neopixel_data out  serial line to the strand
//   ready         out  idle, go will be accepted
//   frame_done    out  one-cycle pulse on the last latch-gap cycle
//   load_err      out  registered pulse for a load with pixel >= NUM_NPX
// ============================================================================
module neopixel_strand_ctrl #(
    parameter int NUM_NPX   = 17,
    parameter int T0H_CYC   = 18,
    parameter int T0L_CYC   = 40,
    parameter int T1H_CYC   = 35,
    parameter int T1L_CYC   = 30,
    parameter int LATCH_CYC = 2500,
    localparam int PIX_W    = (NUM_NPX > 1) ? $clog2(NUM_NPX) : 1
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [7:0]       red,
    input  logic [7:0]       green,
    input  logic [7:0]       blue,
    input  logic [PIX_W-1:0] pixel,
    input  logic             load,
    input  logic             clear,
    input  logic             go,
`ifdef NPX_BRIGHTNESS_EN
    input  logic [7:0]       brightness,
`endif
    output logic             neopixel_data,
    output logic             ready,
    output logic             frame_done,
    output logic             load_err
);

    localparam int NBITS  = NUM_NPX * 24;
    localparam int CNT_W  = $clog2(NBITS + 1);
    localparam int MAX_HI = (T0H_CYC > T1H_CYC) ? T0H_CYC : T1H_CYC;
    localparam int MAX_LO = (T0L_CYC > T1L_CYC) ? T0L_CYC : T1L_CYC;
    localparam int MAX_HL = (MAX_HI > MAX_LO) ? MAX_HI : MAX_LO;
    localparam int MAX_T  = (MAX_HL > LATCH_CYC) ? MAX_HL : LATCH_CYC;
    localparam int TIM_W  = $clog2(MAX_T + 1);

    // The timer counts down to zero, so each phase loads its length minus one.
    localparam logic [TIM_W-1:0] T0H_LD   = TIM_W'(T0H_CYC - 1);
    localparam logic [TIM_W-1:0] T0L_LD   = TIM_W'(T0L_CYC - 1);
    localparam logic [TIM_W-1:0] T1H_LD   = TIM_W'(T1H_CYC - 1);
    localparam logic [TIM_W-1:0] T1L_LD   = TIM_W'(T1L_CYC - 1);
    localparam logic [TIM_W-1:0] LATCH_LD = TIM_W'(LATCH_CYC - 1);
    localparam logic [PIX_W:0]   NPX_LIM  = (PIX_W + 1)'(NUM_NPX);

    typedef enum logic [2:0] {
        ST_START,
        ST_BIT_HI,
        ST_BIT_LO,
        ST_LATCH,
        ST_IDLE
    } state_t;

    state_t             state_q, state_d;
    logic [TIM_W-1:0]   timer_q, timer_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0]   frame_q, frame_d;
    logic [NBITS-1:0]   snap;
    logic [23:0]        buf_q [NUM_NPX];
    logic [23:0]        buf_d [NUM_NPX];
    logic               load_err_q, load_err_d;

`ifdef NPX_BRIGHTNESS_EN
    // 16-bit product; brightness+1 reaches 256, so 255 is an exact pass-through.
    function automatic logic [7:0] scale_byte(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction
`endif

    // State register and all datapath flops.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_START;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            buf_q      <= '{default: '0};
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            buf_q      <= buf_d;
            load_err_q <= load_err_d;
        end
    end

    // Buffer writes. Pixel 0 lands in the top 24 bits of the snapshot so a
    // left shift walks the strand in transmission order.
    always_comb begin
        buf_d      = buf_q;
        load_err_d = load && ({1'b0, pixel} >= NPX_LIM);
        if (clear) begin
            buf_d = '{default: '0};
        end else if (load) begin
            for (int i = 0; i < NUM_NPX; i++) begin
                if (pixel == PIX_W'(i)) begin
                    buf_d[i] = {green, red, blue};
                end
            end
        end
    end

    always_comb begin
        snap = '0;
        for (int i = 0; i < NUM_NPX; i++) begin
`ifdef NPX_BRIGHTNESS_EN
            snap[(NUM_NPX-1-i)*24 +: 24] = {scale_byte(buf_q[i][23:16], brightness),
                                            scale_byte(buf_q[i][15:8],  brightness),
                                            scale_byte(buf_q[i][7:0],   brightness)};
`else
            snap[(NUM_NPX-1-i)*24 +: 24] = buf_q[i];
`endif
        end
    end

    // Next-state logic. The timer is reloaded whenever the state changes,
    // using the bit that will be current in the new state (frame_d MSB).
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        case (state_q)
            ST_START: begin
                frame_d   = snap;
                bit_cnt_d = CNT_W'(NBITS);
                state_d   = ST_BIT_HI;
            end
            ST_BIT_HI: begin
                if (timer_q == '0) state_d = ST_BIT_LO;
                else               timer_d = timer_q - 1'b1;
            end
            ST_BIT_LO: begin
                if (timer_q == '0) begin
                    frame_d   = frame_q << 1;
                    bit_cnt_d = bit_cnt_q - 1'b1;
                    state_d   = (bit_cnt_q == CNT_W'(1)) ? ST_LATCH : ST_BIT_HI;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_LATCH: begin
                if (timer_q == '0) state_d = ST_IDLE;
                else               timer_d = timer_q - 1'b1;
            end
            ST_IDLE: begin
                if (go) state_d = ST_START;
            end
            default: state_d = ST_START;
        endcase

        if (state_d != state_q) begin
            case (state_d)
                ST_BIT_HI: timer_d = frame_d[NBITS-1] ? T1H_LD : T0H_LD;
                ST_BIT_LO: timer_d = frame_d[NBITS-1] ? T1L_LD : T0L_LD;
                ST_LATCH:  timer_d = LATCH_LD;
                default:   timer_d = '0;
            endcase
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        neopixel_data = (state_q == ST_BIT_HI);
        ready         = (state_q == ST_IDLE);
        frame_done    = (state_q == ST_LATCH) && (timer_q == '0);
        load_err      = load_err_q;
    end

endmodule
